measure_seq_ctrl: RTL and testbench
===================================

// Module: measure_seq_ctrl
// PURPOSE
//  Sequencer for the scope measurement datapath: starts a peak-seek window, collects max/min and frequency results.
//  Packs them into one result record (freq, max, min, vpp, flags) and hands it downstream over valid/ready.
//  Supports single-shot and continuous modes, with a timeout and a programmable inter-measurement gap.
//  Sits between the measurement blocks (max/min seeker, frequency counter) and the display/UART reporter.
// PARAMETERS
//  DATA_W      12           ADC sample width, signed
//  FREQ_W      32           frequency result width
//  TIMEOUT_CYC 100_000_000  cycles allowed in WAIT before abort (1 s at 100 MHz)
//  CNT_W       32           width of timeout/gap counter
// PORTS
//  i_clk        in   1        system clock; all inputs synchronous to it
//  i_rst_n      in   1        asynchronous, active-low reset
//  i_start      in   1        single-shot request; sampled in IDLE only
//  i_continuous in   1        1 = re-arm automatically after each result
//  i_gap_cyc    in   CNT_W    idle cycles between measurements (continuous mode)
//  o_trig       out  1        1-cycle pulse starting a max/min window
//  i_mm_vld     in   1        max/min result strobe
//  i_mm_max     in   DATA_W   signed max
//  i_mm_min     in   DATA_W   signed min
//  i_freq_vld   in   1        frequency result strobe
//  i_freq       in   FREQ_W   frequency result
//  o_busy       out  1        high in every state except IDLE
//  o_res_vld    out  1        result record valid
//  i_res_rdy    in   1        downstream ready
//  o_res_freq   out  FREQ_W   latched frequency (0 if timed out)
//  o_res_max    out  DATA_W   latched max (0 if timed out)
//  o_res_min    out  DATA_W   latched min (0 if timed out)
//  o_res_vpp    out  DATA_W+1 max-min, signed-extended subtract, clamped >=0
//  o_res_flags  out  2        [0] freq timeout, [1] max/min timeout
// BEHAVIOUR
//  Reset: async on i_rst_n low. State IDLE. All outputs 0, got_mm/got_freq cleared, counter 0.
//  States: IDLE -> ARM -> WAIT -> OUT -> (GAP -> ARM | IDLE).
//  IDLE: i_start=1 or i_continuous=1 -> ARM. Strobes arriving in IDLE are ignored (stale).
//  ARM: one cycle. o_trig=1, got flags cleared, counter cleared, then -> WAIT.
//   Latency: start seen at cycle N -> o_trig high at N+1.
//  WAIT: first i_mm_vld latches max/min and sets got_mm. First i_freq_vld latches freq and sets got_freq.
//   Later strobes in the same WAIT are ignored. Strobes coinciding in one cycle are both latched.
//   Counter increments each cycle. When got_mm & got_freq -> OUT, with o_res_vld high the next cycle.
//   When counter == TIMEOUT_CYC-1 and still incomplete -> OUT:
//    missing fields = 0; flag bit set per missing result; vpp = 0 if mm missing.
//   A strobe on the timeout cycle itself counts as received.
//  OUT: o_res_vld=1. Record held stable while !i_res_rdy.
//   On the vld&rdy cycle: the transfer completes; o_res_vld drops next cycle.
//   Then -> GAP if i_continuous, else -> IDLE.
//  GAP: counts i_gap_cyc cycles, then -> ARM. i_gap_cyc=0 -> straight to ARM (one cycle in GAP).
//   i_continuous deasserted during GAP -> IDLE on the next cycle.
//  i_start while o_busy: ignored, not queued.
//  vpp: {max[MSB],max} - {min[MSB],min}; a negative result (min>max glitch) is clamped to 0.
//  Counter saturates; it never wraps.
//  Reset mid-operation: immediate abort, no partial record emitted.
// STRUCTURE
//  measure_pkg: state encoding (IDLE/ARM/WAIT/OUT/GAP), flag bit indices, DATA_W/FREQ_W defaults.
//  One sub-module: meas_cycle_timer.
//   Clear/enable saturating CNT_W counter with a terminal-compare output.
//   Shared by the WAIT timeout and the GAP countdown.
//  FSM, result latches and vpp subtract stay in measure_seq_ctrl.
// TESTING
//  1 Single-shot: start pulse, mm_vld(max=1000,min=-1000) @+5, freq_vld(freq=1_000_000) @+20, rdy=1
//    -> trig @+1; one record freq=1000000, vpp=2000, flags=0; then IDLE, busy=0.
//  2 Simultaneous: mm_vld and freq_vld in the same cycle (max=2047,min=-2048)
//    -> both latched, vpp=4095, res_vld next cycle.
//  3 Timeout (TIMEOUT_CYC=50): mm_vld only
//    -> OUT after 50 WAIT cycles, freq=0, flags=2'b01, vpp valid.
//  4 Backpressure: rdy low for 10 cycles during OUT
//    -> record stable all 10 cycles, exactly one transfer, extra freq_vld strobes ignored.
//  5 Continuous, gap=8: three measurements
//    -> trig spacing = WAIT + OUT + 8 cycles; drop i_continuous in GAP -> IDLE, no 4th trig.
//  6 Reset mid-WAIT, plus stale mm_vld in IDLE and start while busy
//    -> all outputs 0 on reset, no record emitted, no extra trig.

Source files
------------

// File: rtl/measure_pkg.sv
// Shared state encoding, flag layout and parameter defaults for the
// scope measurement sequencer.
package measure_pkg;

  localparam int DATA_W_DEF      = 12;
  localparam int FREQ_W_DEF      = 32;
  localparam int CNT_W_DEF       = 32;
  localparam int TIMEOUT_CYC_DEF = 100_000_000;

  localparam int FLAG_FREQ_TO = 0;
  localparam int FLAG_MM_TO   = 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_WAIT = 3'd2,
    ST_OUT  = 3'd3,
    ST_GAP  = 3'd4
  } meas_state_e;

  // One flag bit per result that never arrived before the record closed.
  function automatic logic [1:0] miss_flags(input logic have_freq, input logic have_mm);
    logic [1:0] flags;
    flags               = 2'b00;
    flags[FLAG_FREQ_TO] = ~have_freq;
    flags[FLAG_MM_TO]   = ~have_mm;
    return flags;
  endfunction

endpackage

// File: rtl/meas_cycle_timer.sv
// Saturating cycle counter with clear/enable and a reached-terminal flag;
// shared by the WAIT timeout and the GAP countdown.
module meas_cycle_timer
  import measure_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             reached
);

  logic [CNT_W-1:0] cnt_r;

  // Count while enabled, holding at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (en && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // A >= compare keeps the GAP exit live even if the terminal moves below the count.
  always_comb begin
    reached = (cnt_r >= term);
  end

endmodule

// File: rtl/measure_seq_ctrl.sv
// Measurement sequencer: arms the max/min window, gathers max/min and frequency
// results, and hands one packed record downstream over valid/ready.
module measure_seq_ctrl
  import measure_pkg::*;
#(
  parameter int          DATA_W      = DATA_W_DEF,
  parameter int          FREQ_W      = FREQ_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int          CNT_W       = CNT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_continuous,
  input  logic [CNT_W-1:0]  i_gap_cyc,
  output logic              o_trig,
  input  logic              i_mm_vld,
  input  logic [DATA_W-1:0] i_mm_max,
  input  logic [DATA_W-1:0] i_mm_min,
  input  logic              i_freq_vld,
  input  logic [FREQ_W-1:0] i_freq,
  output logic              o_busy,
  output logic              o_res_vld,
  input  logic              i_res_rdy,
  output logic [FREQ_W-1:0] o_res_freq,
  output logic [DATA_W-1:0] o_res_max,
  output logic [DATA_W-1:0] o_res_min,
  output logic [DATA_W:0]   o_res_vpp,
  output logic [1:0]        o_res_flags
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 32'd1);

  meas_state_e      state_r, state_nxt_s;
  logic             got_mm_r, got_freq_r;
  logic             have_mm_s, have_freq_s;
  logic             tmr_clr_s, tmr_en_s, tmr_reached_s, gap_done_s;
  logic [CNT_W-1:0] tmr_term_s;
  logic             trig_nxt_s, busy_nxt_s, vld_nxt_s;

  // Sign-extended subtract; a min>max glitch yields a negative span, clamped to zero.
  function automatic logic [DATA_W:0] clamp_vpp(input logic [DATA_W-1:0] mx,
                                                 input logic [DATA_W-1:0] mn);
    logic [DATA_W:0] diff;
    diff = {mx[DATA_W-1], mx} - {mn[DATA_W-1], mn};
    if (diff[DATA_W]) begin
      return {(DATA_W+1){1'b0}};
    end else begin
      return diff;
    end
  endfunction

  meas_cycle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .clr     (tmr_clr_s),
    .en      (tmr_en_s),
    .term    (tmr_term_s),
    .reached (tmr_reached_s)
  );

  // Timer control and "result available this cycle" terms.
  always_comb begin
    have_mm_s   = got_mm_r | i_mm_vld;
    have_freq_s = got_freq_r | i_freq_vld;
    tmr_clr_s   = (state_r == ST_ARM) || (state_r == ST_OUT);
    tmr_en_s    = (state_r == ST_WAIT) || (state_r == ST_GAP);
    if (state_r == ST_WAIT) begin
      tmr_term_s = TIMEOUT_LAST;
    end else begin
      tmr_term_s = i_gap_cyc - CNT_W'(1);
    end
    gap_done_s = (i_gap_cyc == {CNT_W{1'b0}}) || tmr_reached_s;
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_start || i_continuous) state_nxt_s = ST_ARM;
        else                         state_nxt_s = ST_IDLE;
      end
      ST_ARM:  state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if ((have_mm_s && have_freq_s) || tmr_reached_s) state_nxt_s = ST_OUT;
        else                                             state_nxt_s = ST_WAIT;
      end
      ST_OUT: begin
        if (!i_res_rdy)        state_nxt_s = ST_OUT;
        else if (i_continuous) state_nxt_s = ST_GAP;
        else                   state_nxt_s = ST_IDLE;
      end
      ST_GAP: begin
        if (!i_continuous)   state_nxt_s = ST_IDLE;
        else if (gap_done_s) state_nxt_s = ST_ARM;
        else                 state_nxt_s = ST_GAP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Control outputs are decoded from the next state so they can be registered.
  always_comb begin
    trig_nxt_s = (state_nxt_s == ST_ARM);
    busy_nxt_s = (state_nxt_s != ST_IDLE);
    vld_nxt_s  = (state_nxt_s == ST_OUT);
  end

  // Registered control outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_trig    <= 1'b0;
      o_busy    <= 1'b0;
      o_res_vld <= 1'b0;
    end else begin
      o_trig    <= trig_nxt_s;
      o_busy    <= busy_nxt_s;
      o_res_vld <= vld_nxt_s;
    end
  end

  // Result latches: cleared on arm, first strobe of each kind wins during WAIT.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      got_mm_r    <= 1'b0;
      got_freq_r  <= 1'b0;
      o_res_freq  <= {FREQ_W{1'b0}};
      o_res_max   <= {DATA_W{1'b0}};
      o_res_min   <= {DATA_W{1'b0}};
      o_res_vpp   <= {(DATA_W+1){1'b0}};
      o_res_flags <= 2'b00;
    end else if (state_r == ST_ARM) begin
      got_mm_r    <= 1'b0;
      got_freq_r  <= 1'b0;
      o_res_freq  <= {FREQ_W{1'b0}};
      o_res_max   <= {DATA_W{1'b0}};
      o_res_min   <= {DATA_W{1'b0}};
      o_res_vpp   <= {(DATA_W+1){1'b0}};
      o_res_flags <= 2'b00;
    end else if (state_r == ST_WAIT) begin
      if (i_mm_vld && !got_mm_r) begin
        got_mm_r  <= 1'b1;
        o_res_max <= i_mm_max;
        o_res_min <= i_mm_min;
        o_res_vpp <= clamp_vpp(i_mm_max, i_mm_min);
      end
      if (i_freq_vld && !got_freq_r) begin
        got_freq_r <= 1'b1;
        o_res_freq <= i_freq;
      end
      if (state_nxt_s == ST_OUT) begin
        o_res_flags <= miss_flags(have_freq_s, have_mm_s);
      end
    end
  end

endmodule

// File: tb/tb_measure_seq_ctrl.sv
// Bench for measure_seq_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model.
module tb_measure_seq_ctrl;

  localparam int DW = 12;
  localparam int FW = 32;
  localparam int CW = 32;
  localparam int TO = 50;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, cont = 1'b0, mm_vld = 1'b0, freq_vld = 1'b0, res_rdy = 1'b0;
  logic [CW-1:0] gap = '0;
  logic [DW-1:0] mm_max = '0, mm_min = '0;
  logic [FW-1:0] freq = '0;
  logic          trig, busy, res_vld;
  logic [FW-1:0] res_freq;
  logic [DW-1:0] res_max, res_min;
  logic [DW:0]   res_vpp;
  logic [1:0]    res_flags;

  measure_seq_ctrl #(.DATA_W(DW), .FREQ_W(FW), .TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_continuous(cont), .i_gap_cyc(gap),
    .o_trig(trig), .i_mm_vld(mm_vld), .i_mm_max(mm_max), .i_mm_min(mm_min),
    .i_freq_vld(freq_vld), .i_freq(freq), .o_busy(busy), .o_res_vld(res_vld),
    .i_res_rdy(res_rdy), .o_res_freq(res_freq), .o_res_max(res_max), .o_res_min(res_min),
    .o_res_vpp(res_vpp), .o_res_flags(res_flags)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {P_IDLE, P_ARM, P_WAIT, P_OUT, P_GAP} phase_e;
  phase_e phase = P_IDLE;
  bit     m_got_mm, m_got_freq;
  int     m_max, m_min, m_wait_n, m_gap_left;
  longint m_freq;
  bit [1:0] m_flags;
  bit     exp_trig, exp_busy, exp_vld;

  function automatic longint m_vpp();
    if (!m_got_mm) return 0;
    else if (m_max > m_min) return m_max - m_min;
    else return 0;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      phase = P_IDLE; m_got_mm = 0; m_got_freq = 0; m_max = 0; m_min = 0; m_freq = 0;
      m_flags = 0; m_wait_n = 0; m_gap_left = 0; exp_trig = 0; exp_busy = 0; exp_vld = 0;
    end else begin
      case (phase)
        P_IDLE: if (start || cont) phase = P_ARM;
        P_ARM: begin
          m_got_mm = 0; m_got_freq = 0; m_max = 0; m_min = 0; m_freq = 0;
          m_flags = 0; m_wait_n = 0; phase = P_WAIT;
        end
        P_WAIT: begin
          if (mm_vld && !m_got_mm) begin
            m_got_mm = 1; m_max = int'($signed(mm_max)); m_min = int'($signed(mm_min));
          end
          if (freq_vld && !m_got_freq) begin
            m_got_freq = 1; m_freq = longint'(freq);
          end
          m_wait_n++;
          if ((m_got_mm && m_got_freq) || m_wait_n >= TO) begin
            m_flags = {!m_got_mm, !m_got_freq};
            phase   = P_OUT;
          end
        end
        P_OUT: if (res_rdy) begin
          phase      = cont ? P_GAP : P_IDLE;
          m_gap_left = (gap == 0) ? 1 : int'(gap);
        end
        P_GAP: begin
          if (!cont) phase = P_IDLE;
          else begin
            m_gap_left--;
            if (m_gap_left == 0) phase = P_ARM;
          end
        end
        default: phase = P_IDLE;
      endcase
      exp_trig = (phase == P_ARM);
      exp_busy = (phase != P_IDLE);
      exp_vld  = (phase == P_OUT);
    end
  end

  // ---------------- cycle counter, compare and logging ----------------
  typedef struct { longint freq; longint max; longint min; longint vpp; longint flags; } rec_t;
  rec_t rec_q[$];
  int   trig_q[$];
  int   vld_q[$];
  bit   prev_vld = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    chk("trig", trig, exp_trig);
    chk("busy", busy, exp_busy);
    chk("res_vld", res_vld, exp_vld);
    if (exp_vld) begin
      chk("rec_freq", res_freq, m_freq);
      chk("rec_max", $signed(res_max), m_max);
      chk("rec_min", $signed(res_min), m_min);
      chk("rec_vpp", res_vpp, m_vpp());
      chk("rec_flags", res_flags, m_flags);
    end
    if (trig) trig_q.push_back(cyc);
    if (res_vld && !prev_vld) vld_q.push_back(cyc);
    if (res_vld && res_rdy) begin
      rec_t r;
      r.freq = res_freq; r.max = $signed(res_max); r.min = $signed(res_min);
      r.vpp = res_vpp; r.flags = res_flags;
      rec_q.push_back(r);
    end
    prev_vld = res_vld;
  end

  // ---------------- driver helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    trig_q.delete(); vld_q.delete(); rec_q.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic wait_trig(input string name, input int budget, output int t);
    bit ok = 0;
    t = -1;
    for (int i = 0; i < budget; i++) begin
      if (trig) begin ok = 1; t = cyc; break; end
      tick(1);
    end
    if (!ok) chk({name, " trig wait expired"}, 0, 1);
  endtask

  task automatic wait_vld(input string name, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (res_vld) begin ok = 1; break; end
      tick(1);
    end
    if (!ok) chk({name, " vld wait expired"}, 0, 1);
  endtask

  task automatic strobe(input bit do_mm, input int mx, input int mn, input bit do_f, input longint f);
    mm_vld = do_mm; mm_max = DW'(mx); mm_min = DW'(mn);
    freq_vld = do_f; freq = FW'(f);
    tick(1);
    mm_vld = 1'b0; freq_vld = 1'b0;
  endtask

  task automatic chk_rec(input string name, input longint f, input longint mx, input longint mn,
                         input longint vpp, input longint flags);
    rec_t r;
    chk({name, " record count"}, rec_q.size(), 1);
    if (rec_q.size() > 0) begin
      r = rec_q.pop_front();
      chk({name, " freq"}, r.freq, f);
      chk({name, " max"}, r.max, mx);
      chk({name, " min"}, r.min, mn);
      chk({name, " vpp"}, r.vpp, vpp);
      chk({name, " flags"}, r.flags, flags);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " trig"}, trig, 0);
    chk({name, " busy"}, busy, 0);
    chk({name, " vld"}, res_vld, 0);
    chk({name, " freq"}, res_freq, 0);
    chk({name, " max"}, res_max, 0);
    chk({name, " min"}, res_min, 0);
    chk({name, " vpp"}, res_vpp, 0);
    chk({name, " flags"}, res_flags, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int s, t, k;
    tick(3);
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick(2);

    // 1: single shot
    clear_logs(); res_rdy = 1'b1;
    s = cyc; pulse_start();
    tick(4); strobe(1, 1000, -1000, 0, 0);
    tick(14); strobe(0, 0, 0, 1, 1_000_000);
    wait_vld("t1", 20); tick(3);
    chk("t1 trig count", trig_q.size(), 1);
    if (trig_q.size() > 0) chk("t1 trig latency", trig_q[0] - s, 1);
    chk_rec("t1", 1_000_000, 1000, -1000, 2000, 0);
    chk("t1 idle busy", busy, 0);

    // 2: simultaneous strobes at the signed extremes
    clear_logs(); pulse_start();
    wait_trig("t2", 10, t); tick(2);
    k = cyc; strobe(1, 2047, -2048, 1, 5000);
    wait_vld("t2", 10); tick(2);
    chk("t2 vld seen", vld_q.size(), 1);
    if (vld_q.size() > 0) chk("t2 vld latency", vld_q[0] - k, 1);
    chk_rec("t2", 5000, 2047, -2048, 4095, 0);

    // 3: timeout with max/min only
    clear_logs(); pulse_start();
    wait_trig("t3", 10, t); tick(3);
    strobe(1, 300, -200, 0, 0);
    wait_vld("t3", 80); tick(2);
    if (vld_q.size() > 0) chk("t3 out after timeout", vld_q[0] - t, TO + 1);
    chk_rec("t3", 0, 300, -200, 500, 1);

    // 4: backpressure with late frequency strobes
    clear_logs(); res_rdy = 1'b0; pulse_start();
    wait_trig("t4", 10, t); tick(2);
    strobe(1, 100, -50, 1, 777);
    wait_vld("t4", 10);
    for (int i = 0; i < 10; i++) begin
      freq_vld = (i % 2 == 0); freq = 32'd999;
      tick(1);
    end
    freq_vld = 1'b0;
    chk("t4 no transfer while stalled", rec_q.size(), 0);
    res_rdy = 1'b1; tick(4);
    chk_rec("t4", 777, 100, -50, 150, 0);

    // 5: continuous mode with an 8-cycle gap
    clear_logs(); gap = 32'd8; cont = 1'b1; tick(1);
    for (int m = 0; m < 3; m++) begin
      wait_trig("t5", 40, t);
      tick(4); strobe(1, 20 + m, -20, 1, 100 + m);
    end
    wait_vld("t5", 10); tick(1);
    cont = 1'b0; tick(30);
    chk("t5 trig count", trig_q.size(), 3);
    if (trig_q.size() >= 3) begin
      chk("t5 spacing 1", trig_q[1] - trig_q[0], 14);
      chk("t5 spacing 2", trig_q[2] - trig_q[1], 14);
    end
    chk("t5 records", rec_q.size(), 3);
    chk("t5 idle busy", busy, 0);

    // 6: reset mid-WAIT, stale strobe in IDLE, start while busy
    clear_logs(); gap = 32'd0; pulse_start();
    wait_trig("t6", 10, t); tick(3);
    pulse_start(); tick(2);
    rst_n = 1'b0; #2;
    chk_all_zero("t6 in reset");
    tick(2); rst_n = 1'b1; tick(10);
    chk("t6 trig before reset", trig_q.size(), 1);
    chk("t6 no record", rec_q.size(), 0);
    clear_logs();
    strobe(1, 500, -500, 0, 0);
    pulse_start();
    wait_trig("t6b", 10, t); tick(2);
    strobe(0, 0, 0, 1, 4242);
    pulse_start();
    wait_vld("t6b", 80); tick(12);
    chk("t6 single trig", trig_q.size(), 1);
    chk_rec("t6", 4242, 0, 0, 0, 2);

    // randomized traffic, segments differ in strobe rate and gap
    for (int seg = 0; seg < 6; seg++) begin
      int p_mm, p_f;
      p_mm = (seg < 2) ? 80 : 10;
      p_f  = (seg < 2) ? 70 : 12;
      gap  = CW'($urandom_range(0, 5));
      cont = 1'b0;
      for (int c = 0; c < 400; c++) begin
        start    = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 49) == 0) cont = ~cont;
        mm_vld   = ($urandom_range(0, p_mm - 1) == 0);
        mm_max   = DW'($urandom);
        mm_min   = DW'($urandom);
        freq_vld = ($urandom_range(0, p_f - 1) == 0);
        freq     = $urandom;
        res_rdy  = ($urandom_range(0, 2) != 0);
        tick(1);
      end
      start = 1'b0; cont = 1'b0; mm_vld = 1'b0; freq_vld = 1'b0; res_rdy = 1'b1;
      tick(TO + 20);
      chk("random drain busy", busy, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
